// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite blitter: FSM states, palette index type and
// default screen geometry.
package sprite_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDrain,
    StFinish
  } state_e;

  typedef logic [2:0] pix_t;

  localparam pix_t PixTransparent = 3'd0;

  localparam int unsigned ScrWDefault = 640;
  localparam int unsigned ScrHDefault = 480;

endpackage

// File: rtl/sprite_blitter.sv
// Copies a SPR_W x SPR_H sprite from ROM into the framebuffer, skipping transparent and
// off-screen pixels. Defining BLIT_FLIP_EN adds the flip port for horizontal mirroring.
module sprite_blitter
  import sprite_pkg::*;
#(
  parameter int unsigned SPR_W = 32,
  parameter int unsigned SPR_H = 53,
  parameter int unsigned SCR_W = ScrWDefault,
  parameter int unsigned SCR_H = ScrHDefault
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [9:0]  pos_x,
  input  logic [9:0]  pos_y,
`ifdef BLIT_FLIP_EN
  input  logic        flip,
`endif
  output logic        busy,
  output logic        done,
  output logic [18:0] rom_addr,
  input  pix_t        rom_data,
  output logic        fb_we,
  output logic [18:0] fb_addr,
  output pix_t        fb_data,
  input  logic        fb_ready
);

  localparam int unsigned CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int unsigned RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

  state_e          state;
  logic [CW-1:0]   col, col_nxt;
  logic [RW-1:0]   row, row_nxt;
  logic [9:0]      x0, y0;
  logic            flip_q, flip_in;
  logic [10:0]     x_sum, y_sum;
  logic            last_pix, stall, pix_vis;

`ifdef BLIT_FLIP_EN
  assign flip_in = flip;
`else
  assign flip_in = 1'b0;
`endif

  function automatic logic [18:0] rom_index(input logic [RW-1:0] r, input logic [CW-1:0] c,
                                            input logic f);
    logic [CW-1:0] cc;
    cc = f ? (CW'(SPR_W - 1) - c) : c;
    return 19'(r) * 19'(SPR_W) + 19'(cc);
  endfunction

  // 11-bit sums keep off-screen coordinates from wrapping back on screen.
  assign x_sum    = {1'b0, x0} + 11'(col);
  assign y_sum    = {1'b0, y0} + 11'(row);
  assign last_pix = (col == CW'(SPR_W - 1)) && (row == RW'(SPR_H - 1));
  assign stall    = fb_we && !fb_ready;
  assign pix_vis  = (rom_data != PixTransparent) && (x_sum < 11'(SCR_W)) &&
                    (y_sum < 11'(SCR_H));

  always_comb begin
    col_nxt = col + CW'(1);
    row_nxt = row;
    if (col == CW'(SPR_W - 1)) begin
      col_nxt = '0;
      row_nxt = row + RW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= StIdle;
      busy     <= 1'b0;
      done     <= 1'b0;
      fb_we    <= 1'b0;
      rom_addr <= '0;
      fb_addr  <= '0;
      fb_data  <= PixTransparent;
      col      <= '0;
      row      <= '0;
      x0       <= '0;
      y0       <= '0;
      flip_q   <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          done  <= 1'b0;
          fb_we <= 1'b0;
          if (start) begin
            x0       <= pos_x;
            y0       <= pos_y;
            flip_q   <= flip_in;
            col      <= '0;
            row      <= '0;
            rom_addr <= rom_index('0, '0, flip_in);
            busy     <= 1'b1;
            state    <= StFetch;
          end
        end
        StFetch: begin
          if (!stall) begin
            fb_we <= pix_vis;
            if (pix_vis) begin
              fb_addr <= 19'(y_sum) * 19'(SCR_W) + 19'(x_sum);
              fb_data <= rom_data;
            end
            if (last_pix) begin
              state <= StDrain;
            end else begin
              col      <= col_nxt;
              row      <= row_nxt;
              rom_addr <= rom_index(row_nxt, col_nxt, flip_q);
            end
          end
        end
        StDrain: begin
          if (!stall) begin
            fb_we <= 1'b0;
            done  <= 1'b1;
            state <= StFinish;
          end
        end
        StFinish: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench for sprite_blitter: randomized ROM images, positions and fb_ready
// patterns compared against a raster-order reference model of the blit.
`timescale 1ns/1ps
module tb_sprite_blitter;
  import sprite_pkg::*;

  localparam int SW = 32;
  localparam int SH = 53;
  localparam int NPIX = SW * SH;
  localparam int XW = 640;
  localparam int YH = 480;
  localparam int PATN = 8192;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        fb_ready = 1'b1;
  logic [9:0]  pos_x = '0;
  logic [9:0]  pos_y = '0;
  logic        flip = 1'b0;
  logic        busy, done, fb_we;
  logic [18:0] rom_addr, fb_addr;
  pix_t        rom_data, fb_data;

  pix_t        rom [NPIX];
  assign rom_data = (rom_addr < 19'(NPIX)) ? rom[rom_addr[10:0]] : PixTransparent;

  sprite_blitter dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .pos_x    (pos_x),
    .pos_y    (pos_y),
`ifdef BLIT_FLIP_EN
    .flip     (flip),
`endif
    .busy     (busy),
    .done     (done),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .fb_we    (fb_we),
    .fb_addr  (fb_addr),
    .fb_data  (fb_data),
    .fb_ready (fb_ready)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  logic [18:0] exp_addr[$], obs_addr[$];
  pix_t        exp_data[$], obs_data[$];
  bit          vis[NPIX];
  bit          pat[PATN];
  int          lat, exp_lat, busy_bad, stall_bad, done_bad;

  function automatic bit pat_at(input int t);
    return (t < PATN) ? pat[t] : 1'b1;
  endfunction

  function automatic int first_diff();
    int n;
    n = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++)
      if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) return i;
    return (obs_addr.size() == exp_addr.size()) ? -1 : n;
  endfunction

  // Reference: visit sprite pixels in raster order, place at (px+c, py+r), keep the visible ones.
  task automatic build_expected(input int px, input int py, input bit fl);
    int src, x, y;
    pix_t d;
    exp_addr.delete();
    exp_data.delete();
    for (int r = 0; r < SH; r++)
      for (int c = 0; c < SW; c++) begin
        src = r * SW + (fl ? SW - 1 - c : c);
        d = rom[src];
        x = px + c;
        y = py + r;
        vis[r * SW + c] = (d != 0) && (x < XW) && (y < YH);
        if (vis[r * SW + c]) begin
          exp_addr.push_back(19'(y * XW + x));
          exp_data.push_back(d);
        end
      end
    // One pixel fetched per edge; a visible pixel waits in the stage until fb_ready.
    exp_lat = 1;
    for (int i = 0; i < NPIX; i++) begin
      int t;
      t = exp_lat + 1;
      while (vis[i] && !pat_at(t)) t++;
      exp_lat = t;
    end
  endtask

  task automatic run_blit(input int px, input int py, input bit fl, input int mode,
                          input bit poke, input int stop_after);
    bit stall_prev;
    logic [18:0] pa;
    pix_t pd;
    bit fl_eff;
`ifdef BLIT_FLIP_EN
    fl_eff = fl;
`else
    fl_eff = 1'b0;
`endif
    for (int k = 0; k < PATN; k++)
      pat[k] = (mode == 0) ? 1'b1 : (mode == 1) ? k[0] : ($urandom_range(3) != 0);
    build_expected(px, py, fl_eff);
    obs_addr.delete();
    obs_data.delete();
    busy_bad = 0; stall_bad = 0; done_bad = 0; lat = -1;
    stall_prev = 1'b0; pa = '0; pd = '0;
    @(negedge clk);
    pos_x = 10'(px); pos_y = 10'(py); flip = fl_eff; start = 1'b1; fb_ready = pat[0];
    for (int j = 0; j < 6000; j++) begin
      @(negedge clk);
      fb_ready = pat_at(j + 1);
      if (stall_prev && (fb_addr !== pa || fb_data !== pd)) stall_bad++;
      if (busy !== 1'b1) busy_bad++;
      if (fb_we === 1'b1 && fb_ready) begin
        obs_addr.push_back(fb_addr);
        obs_data.push_back(fb_data);
      end
      stall_prev = (fb_we === 1'b1) && !fb_ready;
      pa = fb_addr; pd = fb_data;
      if (done === 1'b1) begin
        lat = j;
        break;
      end
      if (stop_after > 0 && obs_addr.size() >= stop_after) break;
      start = poke ? ($urandom_range(3) == 0) : 1'b0;
      if (poke) begin
        pos_x = 10'($urandom); pos_y = 10'($urandom); flip = 1'($urandom);
      end
    end
    start = 1'b0;
    if (lat >= 0) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) done_bad = 1;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", busy); end
    compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL reset_done: got %b want 0", done); end
    compared++; if (fb_we !== 1'b0) begin mismatched++; $display("FAIL reset_fb_we: got %b want 0", fb_we); end
    compared++; if (rom_addr !== 19'd0) begin mismatched++; $display("FAIL reset_rom_addr: got %0d want 0", rom_addr); end
    compared++; if (fb_addr !== 19'd0) begin mismatched++; $display("FAIL reset_fb_addr: got %0d want 0", fb_addr); end
    compared++; if (fb_data !== 3'd0) begin mismatched++; $display("FAIL reset_fb_data: got %0d want 0", fb_data); end
    rst = 1'b0;
  endtask

  task automatic test_solid();
    int d;
    for (int i = 0; i < NPIX; i++) rom[i] = 3'd5;
    run_blit(100, 50, 1'b0, 0, 1'b0, 0);
    d = first_diff();
    compared++; if (obs_addr.size() != 1696) begin mismatched++; $display("FAIL solid_count: got %0d want 1696", obs_addr.size()); end
    compared++; if (obs_addr.size() == 0 || obs_addr[0] !== 19'd32100) begin mismatched++; $display("FAIL solid_first_addr: got %0d want 32100", (obs_addr.size() > 0) ? obs_addr[0] : 19'h7ffff); end
    compared++; if (obs_addr.size() == 0 || obs_addr[$] !== 19'd65411) begin mismatched++; $display("FAIL solid_last_addr: got %0d want 65411", (obs_addr.size() > 0) ? obs_addr[$] : 19'h7ffff); end
    compared++; if (d != -1) begin mismatched++; $display("FAIL solid_stream: first difference at write %0d, want none", d); end
    compared++; if (lat != 1697) begin mismatched++; $display("FAIL solid_latency: got %0d want 1697", lat); end
    compared++; if (busy_bad != 0) begin mismatched++; $display("FAIL solid_busy: got %0d low cycles want 0", busy_bad); end
    compared++; if (done_bad != 0) begin mismatched++; $display("FAIL solid_done_pulse: got %0d want 0", done_bad); end
  endtask

  task automatic test_transparent();
    int d, zeros;
    for (int i = 0; i < NPIX; i++) rom[i] = (i % 2 == 0) ? 3'd0 : 3'($urandom_range(7, 1));
    run_blit($urandom_range(608), $urandom_range(427), 1'b0, 0, 1'b0, 0);
    d = first_diff();
    zeros = 0;
    foreach (obs_data[i]) if (obs_data[i] == 3'd0) zeros++;
    compared++; if (obs_addr.size() != 848) begin mismatched++; $display("FAIL transp_count: got %0d want 848", obs_addr.size()); end
    compared++; if (zeros != 0) begin mismatched++; $display("FAIL transp_zero_data: got %0d want 0", zeros); end
    compared++; if (d != -1) begin mismatched++; $display("FAIL transp_stream: first difference at write %0d, want none", d); end
    compared++; if (lat != exp_lat) begin mismatched++; $display("FAIL transp_latency: got %0d want %0d", lat, exp_lat); end
  endtask

  task automatic test_clip();
    int d, hi;
    for (int i = 0; i < NPIX; i++) rom[i] = 3'($urandom_range(7, 1));
    run_blit(620, 470, 1'b0, 0, 1'b0, 0);
    d = first_diff();
    hi = 0;
    foreach (obs_addr[i]) if (obs_addr[i] >= 19'd307200) hi++;
    compared++; if (obs_addr.size() != 200) begin mismatched++; $display("FAIL clip_count: got %0d want 200", obs_addr.size()); end
    compared++; if (hi != 0) begin mismatched++; $display("FAIL clip_range: got %0d out-of-screen writes want 0", hi); end
    compared++; if (d != -1) begin mismatched++; $display("FAIL clip_stream: first difference at write %0d, want none", d); end
    compared++; if (lat != 1697) begin mismatched++; $display("FAIL clip_latency: got %0d want 1697", lat); end
  endtask

  task automatic test_stall();
    int d;
    for (int i = 0; i < NPIX; i++) rom[i] = 3'($urandom_range(7, 1));
    run_blit($urandom_range(608), $urandom_range(427), 1'b0, 1, 1'b0, 0);
    d = first_diff();
    compared++; if (obs_addr.size() != 1696) begin mismatched++; $display("FAIL stall_count: got %0d want 1696", obs_addr.size()); end
    compared++; if (d != -1) begin mismatched++; $display("FAIL stall_stream: first difference at write %0d, want none", d); end
    compared++; if (stall_bad != 0) begin mismatched++; $display("FAIL stall_hold: got %0d unstable cycles want 0", stall_bad); end
    compared++; if (lat != exp_lat) begin mismatched++; $display("FAIL stall_latency: got %0d want %0d", lat, exp_lat); end
  endtask

  task automatic test_back_to_back();
    int d;
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < NPIX; i++) rom[i] = 3'($urandom_range(7));
      run_blit($urandom_range(1023), $urandom_range(1023), 1'($urandom), 2, 1'b1, 0);
      d = first_diff();
      compared++; if (d != -1) begin mismatched++; $display("FAIL b2b%0d_stream: first difference at write %0d of %0d, want none", n, d, exp_addr.size()); end
      compared++; if (lat != exp_lat) begin mismatched++; $display("FAIL b2b%0d_latency: got %0d want %0d", n, lat, exp_lat); end
      compared++; if (stall_bad != 0 || done_bad != 0 || busy_bad != 0) begin mismatched++; $display("FAIL b2b%0d_handshake: got stall=%0d done=%0d busy=%0d want 0", n, stall_bad, done_bad, busy_bad); end
    end
  endtask

  task automatic test_reset_mid();
    int bad, d;
    for (int i = 0; i < NPIX; i++) rom[i] = 3'($urandom_range(7, 1));
    run_blit(10, 10, 1'b0, 0, 1'b0, 500);
    rst = 1'b1;
    #1;
    compared++; if (fb_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin mismatched++; $display("FAIL midreset_outputs: got we=%b busy=%b done=%b want 0", fb_we, busy, done); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (fb_we !== 1'b0 || done !== 1'b0 || busy !== 1'b0) bad++;
    end
    compared++; if (bad != 0) begin mismatched++; $display("FAIL midreset_quiet: got %0d active cycles want 0", bad); end
    run_blit(0, 0, 1'b0, 0, 1'b0, 0);
    d = first_diff();
    compared++; if (d != -1) begin mismatched++; $display("FAIL midreset_restart: first difference at write %0d, want none", d); end
    compared++; if (lat != 1697) begin mismatched++; $display("FAIL midreset_latency: got %0d want 1697", lat); end
  endtask

`ifdef BLIT_FLIP_EN
  task automatic test_flip();
    int d;
    for (int i = 0; i < NPIX; i++) rom[i] = 3'($urandom_range(7, 1));
    rom[0] = 3'd1;
    rom[31] = 3'd6;
    run_blit(0, 0, 1'b1, 0, 1'b1, 0);
    d = first_diff();
    compared++; if (obs_addr.size() == 0 || obs_addr[0] !== 19'd0 || obs_data[0] !== 3'd6) begin mismatched++; $display("FAIL flip_first: got addr=%0d data=%0d want addr=0 data=6", (obs_addr.size() > 0) ? obs_addr[0] : 19'h7ffff, (obs_data.size() > 0) ? obs_data[0] : 3'd0); end
    compared++; if (d != -1) begin mismatched++; $display("FAIL flip_stream: first difference at write %0d, want none", d); end
    compared++; if (obs_addr.size() != 1696) begin mismatched++; $display("FAIL flip_count: got %0d want 1696", obs_addr.size()); end
  endtask
`endif

  initial begin
    for (int i = 0; i < NPIX; i++) rom[i] = '0;
    test_reset();
    test_solid();
    test_transparent();
    test_clip();
    test_stall();
    test_back_to_back();
    test_reset_mid();
`ifdef BLIT_FLIP_EN
    test_flip();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
